// File: rtl/sprite_anim_renderer.sv
// ----------------------------------------------------------------------------
// sprite_anim_renderer
//
// Purpose:
//   Three-stage sprite pixel pipeline for the VGA path. For every pixel the
//   VGA controller presents (DrawX/DrawY/blank), it checks whether the pixel
//   falls inside the sprite box, generates a registered address into an
//   external synchronous sprite ROM, and one cycle after the ROM responds it
//   registers the palette colour. Pixels whose ROM index equals TRANSP_IDX,
//   pixels outside the box and pixels outside active video come out black
//   with pixel_on=0. An animation counter steps through FRAMES images stored
//   back-to-back in the ROM, advancing every HOLD frame_tick pulses.
//
//   The pipeline has no backpressure: one pixel enters and one pixel leaves
//   every vga_clk cycle, with a fixed latency of 3 cycles.
//
// Optional feature (macro SPRITE_MIRROR_EN):
//   When defined, adds the input 'mirror'; mirror=1 flips the sprite
//   horizontally (dx -> SPR_W-1-dx). Bounds and latency are unchanged.
//
// Ports:
//   vga_clk      in   pixel clock, all state on posedge
//   reset        in   synchronous, active-high
//   DrawX/DrawY  in   current pixel column/row (10 bits)
//   blank        in   1 = active video
//   SpriteX/Y    in   sprite top-left column/row (10 bits)
//   frame_tick   in   one-cycle pulse per video frame
//   anim_en      in   1 = animation advances
//   restart      in   pulse: back to frame 0, hold counter cleared
//   mirror       in   (SPRITE_MIRROR_EN only) horizontal flip
//   rom_address  out  registered sprite ROM address
//   rom_q        in   ROM data, valid one cycle after rom_address
//   pal_index    out  rom_q forwarded to a combinational palette
//   pal_red/green/blue  in  palette colour for pal_index
//   red/green/blue      out registered pixel colour
//   pixel_on     out  registered: opaque sprite pixel in active video
//   frame_idx    out  current animation frame
// ----------------------------------------------------------------------------
module sprite_anim_renderer #(
    parameter int              SPR_W      = 20,
    parameter int              SPR_H      = 20,
    parameter int              FRAMES     = 4,
    parameter int              HOLD       = 8,
    parameter int              IDX_W      = 8,
    parameter logic [IDX_W-1:0] TRANSP_IDX = '0,
    parameter int              ADDR_W     = $clog2(FRAMES*SPR_W*SPR_H),
    localparam int             FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [9:0]          SpriteX,
    input  logic [9:0]          SpriteY,
    input  logic                frame_tick,
    input  logic                anim_en,
    input  logic                restart,
`ifdef SPRITE_MIRROR_EN
    input  logic                mirror,
`endif
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_W-1:0]    rom_q,
    output logic [IDX_W-1:0]    pal_index,
    input  logic [3:0]          pal_red,
    input  logic [3:0]          pal_green,
    input  logic [3:0]          pal_blue,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                pixel_on,
    output logic [FRAME_W-1:0]  frame_idx
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [ADDR_W-1:0]  FRAME_SZ_A = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]  SPR_W_A    = ADDR_W'(SPR_W);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
    localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(HOLD - 1);

    // ------------------------------------------------------------------
    // Animation counter
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    // restart outranks a coincident frame_tick; reset outranks both.
    always_comb begin
        frame_idx_d = frame_idx_q;
        hold_d      = hold_q;
        if (restart) begin
            frame_idx_d = '0;
            hold_d      = '0;
        end else if (frame_tick && anim_en) begin
            if (hold_q == LAST_HOLD) begin
                hold_d      = '0;
                frame_idx_d = (frame_idx_q == LAST_FRAME) ? '0 : frame_idx_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_idx_q <= '0;
            hold_q      <= '0;
        end else begin
            frame_idx_q <= frame_idx_d;
            hold_q      <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: bounds check and address generation
    // ------------------------------------------------------------------
    // Bounds are compared in 11 bits so a sprite hanging off the right or
    // bottom edge (SpriteX+SPR_W > 1023) cannot wrap and hit low columns.
    logic [10:0]       draw_x_w, draw_y_w, spr_x_w, spr_y_w;
    logic              in_box;
    logic [9:0]        dx, dy, dx_eff;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        draw_x_w = {1'b0, DrawX};
        draw_y_w = {1'b0, DrawY};
        spr_x_w  = {1'b0, SpriteX};
        spr_y_w  = {1'b0, SpriteY};
        in_box   = (draw_x_w >= spr_x_w) && (draw_x_w < spr_x_w + 11'(SPR_W)) &&
                   (draw_y_w >= spr_y_w) && (draw_y_w < spr_y_w + 11'(SPR_H));
        dx       = DrawX - SpriteX;
        dy       = DrawY - SpriteY;
`ifdef SPRITE_MIRROR_EN
        dx_eff   = mirror ? (10'(SPR_W - 1) - dx) : dx;
`else
        dx_eff   = dx;
`endif
        // Out-of-box pixels still point at the current frame's first word;
        // the ROM data is ignored for them because the hit flag is clear.
        frame_base = ADDR_W'(frame_idx_q) * FRAME_SZ_A;
        addr_d     = frame_base;
        if (in_box) begin
            addr_d = frame_base + ADDR_W'(dy) * SPR_W_A + ADDR_W'(dx_eff);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    //   edge k+1: address, hit0/blank0
    //   edge k+2: ROM data appears on rom_q, hit/blank delayed once more
    //   edge k+3: colour and pixel_on registered
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rom_address_q;
    logic              hit0_q, blank0_q;
    logic              hit1_q, blank1_q;
    logic              pixel_on_q;
    logic [3:0]        red_q, green_q, blue_q;
    logic              opaque;

    assign opaque = hit1_q && blank1_q && (rom_q != TRANSP_IDX);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address_q <= '0;
            hit0_q        <= 1'b0;
            blank0_q      <= 1'b0;
            hit1_q        <= 1'b0;
            blank1_q      <= 1'b0;
            pixel_on_q    <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            rom_address_q <= addr_d;
            hit0_q        <= in_box;
            blank0_q      <= blank;
            hit1_q        <= hit0_q;
            blank1_q      <= blank0_q;
            pixel_on_q    <= opaque;
            red_q         <= opaque ? pal_red   : 4'h0;
            green_q       <= opaque ? pal_green : 4'h0;
            blue_q        <= opaque ? pal_blue  : 4'h0;
        end
    end

    assign rom_address = rom_address_q;
    assign pal_index   = rom_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign pixel_on    = pixel_on_q;
    assign frame_idx   = frame_idx_q;

endmodule
